// File: rtl/fifo_rd_unpack_32to16.sv
// fifo_rd_unpack_32to16
// Pops 32-bit words from an LSRAM FIFO read port and re-emits them as a
// 16-bit halfword stream with valid/ready handshake. A 2-entry word buffer
// absorbs the FIFO read latency so one halfword per cycle is sustained.
//
// Parameters:
//   RD_LATENCY  cycles from FIFO_RE to FIFO_DATA valid (1 or 2)
//   LOW_FIRST   1: emit FIFO_DATA[15:0] first, 0: emit [31:16] first
// Ports:
//   CLK, RESET_N        clock, async active-low reset
//   FLUSH               sync flush of buffer, phase and in-flight reads
//   FIFO_EMPTY/RE/DATA  FIFO read side
//   DOUT/VALID/READY    halfword output stream
//   PHASE               0 = first half of head word, 1 = second half
// Optional (macro FIFO_RD_UNPACK_STATS_EN):
//   HW_COUNT            transferred halfword count (wrapping)
//   UNDERRUN            sticky: consumer ready with no data after first transfer
module fifo_rd_unpack_32to16 #(
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          LOW_FIRST  = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FLUSH,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RE,
  input  logic [31:0] FIFO_DATA,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  output logic        PHASE
`ifdef FIFO_RD_UNPACK_STATS_EN
  ,
  output logic [15:0] HW_COUNT,
  output logic        UNDERRUN
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned OCC_W  = 2;

  typedef enum logic {
    HALF_A = 1'b0,
    HALF_B = 1'b1
  } phase_t;

  phase_t                  phase_q;
  logic                    run_q;
  logic [RD_LATENCY-1:0]   inflight_q;
  logic [OCC_W-1:0]        occ_q;
  logic [WORD_W-1:0]       head_q;
  logic [WORD_W-1:0]       tail_q;
  logic [OCC_W-1:0]        inflight_cnt;
  logic [OCC_W:0]          committed;
  logic                    xfer;
  logic                    pop;
  logic                    wr;

  // Number of reads issued whose data has not yet returned
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + OCC_W'(inflight_q[i]);
    end
  end

  assign DOUT_VALID = (occ_q != '0);
  assign PHASE      = (phase_q == HALF_B);
  assign xfer       = DOUT_VALID && DOUT_READY;
  assign pop        = xfer && (phase_q == HALF_B);
  // Returning data is dropped during FLUSH; earlier in-flight reads lose their tag
  assign wr         = inflight_q[RD_LATENCY-1] && !FLUSH;

  // Words owned by this block (buffered + in flight) after this cycle's pop
  assign committed  = (OCC_W+1)'(occ_q) + (OCC_W+1)'(inflight_cnt) - (OCC_W+1)'(pop);

  // run_q holds reads off until the first clock edge after reset release
  assign FIFO_RE    = run_q && !FIFO_EMPTY && !FLUSH && (committed < (OCC_W+1)'(2));

  // Halfword select from buffer head
  always_comb begin
    DOUT = '0;
    if (DOUT_VALID) begin
      DOUT = (PHASE == LOW_FIRST) ? head_q[WORD_W-1:HALF_W] : head_q[HALF_W-1:0];
    end
  end

  // Reset-release qualifier
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Phase FSM, in-flight tracking and 2-entry word buffer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase_q    <= HALF_A;
      inflight_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (FLUSH) begin
      phase_q    <= HALF_A;
      inflight_q <= '0;
      occ_q      <= '0;
    end else begin
      inflight_q <= (inflight_q << 1) | RD_LATENCY'(FIFO_RE);
      if (xfer) begin
        phase_q <= (phase_q == HALF_A) ? HALF_B : HALF_A;
      end
      case ({wr, pop})
        2'b11: begin
          // Write and pop together: occupancy unchanged, order preserved
          if (occ_q == OCC_W'(1)) begin
            head_q <= FIFO_DATA;
          end else begin
            head_q <= tail_q;
            tail_q <= FIFO_DATA;
          end
        end
        2'b10: begin
          if (occ_q == '0) head_q <= FIFO_DATA;
          else             tail_q <= FIFO_DATA;
          occ_q <= occ_q + OCC_W'(1);
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - OCC_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_UNPACK_STATS_EN
  logic seen_xfer_q;

  // Halfword counter and sticky underrun flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      HW_COUNT    <= '0;
      UNDERRUN    <= 1'b0;
      seen_xfer_q <= 1'b0;
    end else if (FLUSH) begin
      HW_COUNT    <= '0;
      UNDERRUN    <= 1'b0;
      seen_xfer_q <= 1'b0;
    end else begin
      if (xfer) begin
        HW_COUNT    <= HW_COUNT + 16'd1;
        seen_xfer_q <= 1'b1;
      end
      if (DOUT_READY && !DOUT_VALID && seen_xfer_q) begin
        UNDERRUN <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_unpack_32to16.sv
// Testbench for fifo_rd_unpack_32to16: FIFO read-port model with RD_LATENCY
// pipeline, halfword-stream reference model, directed and random sequences.
module tb_fifo_rd_unpack_32to16;

  localparam int unsigned TB_LAT = 2;
  localparam bit          TB_LOW_FIRST = 1'b1;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fifo_empty;
  logic        fifo_re;
  logic [31:0] fifo_data;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        phase;
`ifdef FIFO_RD_UNPACK_STATS_EN
  logic [15:0] hw_count;
  logic        underrun;
`endif

  fifo_rd_unpack_32to16 #(
    .RD_LATENCY (TB_LAT),
    .LOW_FIRST  (TB_LOW_FIRST)
  ) u_dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .FLUSH      (flush),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_RE    (fifo_re),
    .FIFO_DATA  (fifo_data),
    .DOUT       (dout),
    .DOUT_VALID (dout_valid),
    .DOUT_READY (dout_ready),
    .PHASE      (phase)
`ifdef FIFO_RD_UNPACK_STATS_EN
    ,
    .HW_COUNT   (hw_count),
    .UNDERRUN   (underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Source FIFO contents, read pipeline and expected halfword stream
  logic [31:0] word_q[$];
  logic [31:0] pipe[TB_LAT];
  logic [15:0] exp_hw[$];
  bit          exp_ph[$];
  int          outstanding = 0;

  int cyc = 0;
  int first_re_cyc, first_v_cyc, gaps, xfers, win_n, re_cnt;
  logic last_re, last_v, last_p;
  logic [15:0] last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark(input int n);
    first_re_cyc = -1;
    first_v_cyc  = -1;
    gaps   = 0;
    xfers  = 0;
    win_n  = n;
    re_cnt = 0;
  endtask

  // One clock cycle: sample at negedge, update model, advance FIFO read pipe
  task automatic step();
    logic re, v, p, done;
    logic [15:0] d;
    logic [31:0] w;
    fifo_empty = (word_q.size() == 0);
    @(negedge clk);
    re = fifo_re; v = dout_valid; p = phase; d = dout;
    last_re = re; last_v = v; last_p = p; last_d = d;
    cyc++;
    w = $urandom;
    if (!rst_n) begin
      chk("rst_re", 32'(re), 0);
      chk("rst_valid", 32'(v), 0);
      exp_hw.delete();
      exp_ph.delete();
      outstanding = 0;
    end else begin
      if (re) begin
        re_cnt++;
        if (first_re_cyc < 0) first_re_cyc = cyc;
        chk("re_gating", 32'(fifo_empty | flush), 0);
      end
      if (v) begin
        if (first_v_cyc < 0) first_v_cyc = cyc;
        chk("valid_has_data", 32'(exp_hw.size() != 0), 1);
        if (exp_hw.size() != 0) begin
          chk("dout", 32'(d), 32'(exp_hw[0]));
          chk("phase", 32'(p), 32'(exp_ph[0]));
        end
      end else begin
        chk("dout_idle", 32'(d), 0);
        chk("phase_idle", 32'(p), 0);
        if (first_v_cyc >= 0 && xfers < win_n) gaps++;
      end
      done = 1'b0;
      if (v && dout_ready && exp_hw.size() != 0) begin
        done = exp_ph[0];
        void'(exp_hw.pop_front());
        void'(exp_ph.pop_front());
        xfers++;
      end
      if (re) begin
        chk("credit", 32'((outstanding - int'(done)) < 2), 1);
        if (word_q.size() != 0) begin
          w = word_q.pop_front();
          exp_hw.push_back(TB_LOW_FIRST ? w[15:0] : w[31:16]);
          exp_ph.push_back(1'b0);
          exp_hw.push_back(TB_LOW_FIRST ? w[31:16] : w[15:0]);
          exp_ph.push_back(1'b1);
          outstanding++;
        end
      end
      if (done) outstanding--;
      if (flush) begin
        exp_hw.delete();
        exp_ph.delete();
        outstanding = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = TB_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = re ? w : $urandom;
    fifo_data = pipe[TB_LAT-1];
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((word_q.size() != 0 || exp_hw.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drained", 32'(exp_hw.size() + word_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    dout_ready = 1'b0;
    fifo_data = '0;
    for (int i = 0; i < TB_LAT; i++) pipe[i] = '0;
    mark(0);

    // Reset state with data already waiting in the FIFO
    word_q.push_back(32'hBBBB_AAAA);
    word_q.push_back(32'hDDDD_CCCC);
    fifo_empty = 1'b0;
    #3;
    chk("reset_re", 32'(fifo_re), 0);
    chk("reset_valid", 32'(dout_valid), 0);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_phase", 32'(phase), 0);
    step();
    step();
    rst_n = 1'b1;

    // Basic ordering, latency, back-to-back output
    mark(4);
    dout_ready = 1'b1;
    drain(40);
    chk("first_latency", 32'(first_v_cyc - first_re_cyc), 32'(TB_LAT + 1));
    chk("basic_gaps", 32'(gaps), 0);
    chk("basic_xfers", 32'(xfers), 4);

    // 8 words streamed at full rate
    mark(16);
    for (int i = 0; i < 8; i++) word_q.push_back($urandom);
    drain(60);
    chk("stream_gaps", 32'(gaps), 0);
    chk("stream_xfers", 32'(xfers), 16);
    chk("stream_reads", 32'(re_cnt), 8);

    // Stall pattern 1,0,0,1
    mark(0);
    dout_ready = 1'b0;
    word_q.push_back(32'h1234_5678);
    last_v = 1'b0;
    for (int i = 0; i < 10 && !last_v; i++) step();
    chk("stall_wait_valid", 32'(last_v), 1);
    dout_ready = 1'b1; step();
    chk("stall_first", 32'(last_d), 32'h5678);
    dout_ready = 1'b0; step();
    chk("stall_hold1", 32'(last_d), 32'h1234);
    chk("stall_phase1", 32'(last_p), 1);
    step();
    chk("stall_hold2", 32'(last_d), 32'h1234);
    dout_ready = 1'b1; step();
    chk("stall_last", 32'(last_d), 32'h1234);
    drain(20);
    chk("stall_reads", 32'(re_cnt), 1);

    // Flush one cycle after a read issues
    mark(0);
    word_q.push_back($urandom);
    word_q.push_back(32'h0000_0001);
    last_re = 1'b0;
    for (int i = 0; i < 10 && !last_re; i++) step();
    chk("flush_wait_re", 32'(last_re), 1);
    flush = 1'b1; step();
    chk("flush_re_forced", 32'(last_re), 0);
    flush = 1'b0; step();
    chk("flush_valid", 32'(last_v), 0);
    chk("flush_phase", 32'(last_p), 0);
    drain(30);
    chk("flush_reads", 32'(re_cnt), 2);

    // Asynchronous reset while halfway through a word
    mark(0);
    dout_ready = 1'b0;
    word_q.push_back(32'hCAFE_F00D);
    word_q.push_back(32'h0BAD_BEEF);
    last_v = 1'b0;
    for (int i = 0; i < 10 && !last_v; i++) step();
    dout_ready = 1'b1; step();
    dout_ready = 1'b0; step();
    chk("pre_rst_phase", 32'(last_p), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_re", 32'(fifo_re), 0);
    chk("async_rst_valid", 32'(dout_valid), 0);
    chk("async_rst_dout", 32'(dout), 0);
    chk("async_rst_phase", 32'(phase), 0);
    step();
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    word_q.push_back(32'h5566_7788);
    drain(40);

    // Random traffic with random backpressure and occasional flush
    mark(0);
    for (int i = 0; i < 300; i++) begin
      if (word_q.size() < 6 && $urandom_range(2, 0) == 0) word_q.push_back($urandom);
      dout_ready = ($urandom_range(3, 0) != 0);
      flush = ($urandom_range(39, 0) == 0);
      step();
    end
    flush = 1'b0;
    dout_ready = 1'b1;
    drain(60);

`ifdef FIFO_RD_UNPACK_STATS_EN
    // Halfword counter and underrun flag
    flush = 1'b1; step();
    flush = 1'b0; step();
    chk("stats_clr_count", 32'(hw_count), 0);
    chk("stats_clr_underrun", 32'(underrun), 0);
    for (int i = 0; i < 3; i++) word_q.push_back($urandom);
    drain(40);
    chk("stats_count6", 32'(hw_count), 6);
    chk("stats_no_underrun", 32'(underrun), 0);
    step();
    chk("stats_underrun", 32'(underrun), 1);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("stats_flush_count", 32'(hw_count), 0);
    chk("stats_flush_underrun", 32'(underrun), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
